// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: shares one BFT output link among NUM_OUT_PORTS user streams.
// A round-robin arbiter picks one credited, enabled port per cycle. The winning
// word is stamped with its route (leaf/port) and a per-port wrapping address,
// then lands in the registered output one cycle after the combinational ack.
module leaf_out_arbiter #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 6,
  parameter int CREDIT_BITS   = 8,
  parameter int CREDIT_INIT   = 128
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_we,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic                                  cfg_en,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic                                  credit_vld,
  input  logic [NUM_PORT_BITS-1:0]              credit_port,
  input  logic [CREDIT_BITS-1:0]                credit_amt,
  input  logic                                  out_ready,
  input  logic                                  stall,
  output logic [PACKET_BITS-1:0]                dout_pkt,
  output logic                                  credit_err
);

  localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(NUM_OUT_PORTS - 1);
  localparam logic [NUM_PORT_BITS:0]   NPORTS   = (NUM_PORT_BITS + 1)'(NUM_OUT_PORTS);
  localparam logic [CREDIT_BITS:0]     CRED_MAX = (CREDIT_BITS + 1)'(CREDIT_INIT);
  localparam logic [CREDIT_BITS-1:0]   CRED_RST = CREDIT_BITS'(CREDIT_INIT);

  // Per-port route table and counters
  logic                      en_q     [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]  leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]  port_q   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]  addr_q   [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]    credit_q [NUM_OUT_PORTS];
  logic [PTR_W-1:0]          rr_ptr;

  // Stage 0 (combinational arbitration) signals
  logic [NUM_OUT_PORTS-1:0]  eligible_p0;
  logic                      out_free_p0;
  logic                      arb_en_p0;
  logic                      gnt_vld_p0;
  logic [PTR_W-1:0]          gnt_idx_p0;
  logic [PACKET_BITS-1:0]    gnt_pkt_p0;
  logic [CREDIT_BITS:0]      cred_sum_p0 [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0]  cred_ovf_p0;
  logic                      cfg_bad_p0;
  logic                      credit_bad_p0;

  // Stage 1 (output register) signals
  logic [PACKET_BITS-1:0]    pkt_p1;
  logic                      vld_p1;

  // ---------------- stage 0: arbitration ----------------
  assign vld_p1      = pkt_p1[PACKET_BITS-1];
  assign out_free_p0 = !vld_p1 || (out_ready && !stall);
  assign arb_en_p0   = out_free_p0 && !stall;
  assign cfg_bad_p0    = cfg_we && ({1'b0, cfg_port} >= NPORTS);
  assign credit_bad_p0 = credit_vld && ({1'b0, credit_port} >= NPORTS);

  // A port may compete only with data, an enabled route and a credit left
  always_comb begin
    eligible_p0 = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible_p0[i] = vld_user[i] & en_q[i] & (credit_q[i] != '0);
    end
  end

  // Search starts just after the last winner so every port gets a fair turn
  always_comb begin
    int cand;
    cand       = 0;
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = '0;
    gnt_pkt_p0 = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_OUT_PORTS) cand = cand - NUM_OUT_PORTS;
      if (!gnt_vld_p0 && eligible_p0[cand]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = PTR_W'(cand);
        gnt_pkt_p0 = {1'b1, leaf_q[cand], port_q[cand], addr_q[cand],
                      din_user[cand*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  // One-hot ack to the winner, only when the output register can take it
  always_comb begin
    ack_user = '0;
    if (arb_en_p0 && gnt_vld_p0) ack_user[gnt_idx_p0] = 1'b1;
  end

  // Next credit value: a return and a grant on the same port combine
  always_comb begin
    cred_ovf_p0 = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cred_sum_p0[i] = {1'b0, credit_q[i]}
                     + ((credit_vld && (credit_port == NUM_PORT_BITS'(i))) ? {1'b0, credit_amt} : '0)
                     - {{CREDIT_BITS{1'b0}}, ack_user[i]};
      cred_ovf_p0[i] = cred_sum_p0[i] > CRED_MAX;
    end
  end

  // ---------------- stage 1: registered state ----------------

  // Route table; out-of-range writes match no entry and are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        en_q[i]   <= 1'b0;
        leaf_q[i] <= '0;
        port_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_port == NUM_PORT_BITS'(i)) begin
          en_q[i]   <= cfg_en;
          leaf_q[i] <= cfg_dest_leaf;
          port_q[i] <= cfg_dest_port;
        end
      end
    end
  end

  // Per-port sequence address and saturating credit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        addr_q[i]   <= '0;
        credit_q[i] <= CRED_RST;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (ack_user[i]) addr_q[i] <= addr_q[i] + 1'b1;
        credit_q[i] <= cred_ovf_p0[i] ? CRED_RST : cred_sum_p0[i][CREDIT_BITS-1:0];
      end
    end
  end

  // Output register: load the winner, clear valid when idle, freeze on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_p1 <= '0;
      rr_ptr <= PTR_LAST;
    end else if (arb_en_p0) begin
      if (gnt_vld_p0) begin
        pkt_p1 <= gnt_pkt_p0;
        rr_ptr <= gnt_idx_p0;
      end else begin
        pkt_p1[PACKET_BITS-1] <= 1'b0;
      end
    end
  end

  // Sticky error: bad config index, bad credit index or credit overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_err <= 1'b0;
    end else if (cfg_bad_p0 || credit_bad_p0 || (|cred_ovf_p0)) begin
      credit_err <= 1'b1;
    end
  end

  assign dout_pkt = pkt_p1;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Testbench for leaf_out_arbiter: a scoreboard queues the expected packet for
// every observed ack and compares it against dout_pkt one cycle later.
module tb_leaf_out_arbiter;
  localparam int NP = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [3:0]        cfg_port;
  logic              cfg_en;
  logic [4:0]        cfg_dest_leaf;
  logic [3:0]        cfg_dest_port;
  logic [NP*32-1:0]  din_user;
  logic [NP-1:0]     vld_user;
  logic [NP-1:0]     ack_user;
  logic              credit_vld;
  logic [3:0]        credit_port;
  logic [7:0]        credit_amt;
  logic              out_ready;
  logic              stall;
  logic [48:0]       dout_pkt;
  logic              credit_err;

  leaf_out_arbiter #(.NUM_OUT_PORTS(NP)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_en(cfg_en),
    .cfg_dest_leaf(cfg_dest_leaf), .cfg_dest_port(cfg_dest_port),
    .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
    .credit_vld(credit_vld), .credit_port(credit_port), .credit_amt(credit_amt),
    .out_ready(out_ready), .stall(stall), .dout_pkt(dout_pkt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [48:0] exp_q[$];
  int          gq[$];
  logic [4:0]  m_leaf [NP];
  logic [3:0]  m_port [NP];
  logic [6:0]  m_addr [NP];
  int          seq    [NP];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input int p, input int s);
    logic [31:0] d;
    d = {p[7:0], s[23:0]} ^ 32'h5A00_3C00;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int p, input logic en, input logic [4:0] lf, input logic [3:0] pt);
    step();
    cfg_we = 1'b1; cfg_port = 4'(p); cfg_en = en; cfg_dest_leaf = lf; cfg_dest_port = pt;
    if (p < NP) begin
      m_leaf[p] = lf;
      m_port[p] = pt;
    end
    step();
    cfg_we = 1'b0;
  endtask

  task automatic credit(input int p, input int amt);
    step();
    credit_vld = 1'b1; credit_port = 4'(p); credit_amt = 8'(amt);
    step();
    credit_vld = 1'b0;
  endtask

  task automatic wait_grants(input string tag, input int target, input int budget, output int cyc);
    cyc = 0;
    while (gq.size() < target && cyc < budget) begin
      step();
      cyc++;
    end
    chk(tag, gq.size(), target);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_dout", dout_pkt, 0);
    chk("rst_ack", ack_user, 0);
    exp_q.delete();
    for (int i = 0; i < NP; i++) begin
      m_addr[i] = '0; m_leaf[i] = '0; m_port[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    gq.delete();
    chk("rst_err", credit_err, 0);
  endtask

  // Input data driver: each port presents its next sequence word after every edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) din_user[i*32 +: 32] = mk_data(i, seq[i]);
    end
  end

  // Scoreboard monitor
  initial begin
    logic [48:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pkt", dout_pkt, e);
        end
        chk("ack_onehot", $countones(ack_user) <= 1, 1);
        for (int i = 0; i < NP; i++) begin
          if (ack_user[i]) begin
            exp_q.push_back({1'b1, m_leaf[i], m_port[i], m_addr[i], mk_data(i, seq[i])});
            m_addr[i] = m_addr[i] + 7'd1;
            seq[i]++;
            gq.push_back(i);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    int exp_ord[6];
    logic [48:0] hold;
    reset = 1'b1; cfg_we = 1'b0; cfg_port = '0; cfg_en = 1'b0; cfg_dest_leaf = '0;
    cfg_dest_port = '0; din_user = '0; vld_user = '0; credit_vld = 1'b0;
    credit_port = '0; credit_amt = '0; out_ready = 1'b1; stall = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_leaf[i] = '0; m_port[i] = '0; m_addr[i] = '0;
    end
    #2;
    chk("reset_dout", dout_pkt, 0);
    chk("reset_ack", ack_user, 0);
    chk("reset_err", credit_err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic route on port 0
    cfg(0, 1'b1, 5'd3, 4'd2);
    gq.delete();
    vld_user[0] = 1'b1;
    wait_grants("t1_grants", 2, 10, c);
    vld_user[0] = 1'b0;
    chk("t1_g0", gq[0], 0);
    chk("t1_g1", gq[1], 0);
    step(); step();
    chk("t1_idle", dout_pkt[48], 0);

    // Round robin over ports 0, 2, 5; last winner was port 0
    cfg(2, 1'b1, 5'd9, 4'd1);
    cfg(5, 1'b1, 5'd17, 4'd14);
    gq.delete();
    vld_user = 6'b100101;
    wait_grants("t2_grants", 6, 20, c);
    vld_user = '0;
    chk("t2_cycles", c, 6);
    exp_ord = '{2, 5, 0, 2, 5, 0};
    for (int i = 0; i < 6; i++) chk("t2_order", gq[i], exp_ord[i]);

    // Credit exhaustion and refill on port 1
    cfg(1, 1'b1, 5'd1, 4'd7);
    gq.delete();
    vld_user[1] = 1'b1;
    wait_grants("t3_drain", 128, 200, c);
    repeat (5) step();
    chk("t3_exhaust", gq.size(), 128);
    credit(1, 64);
    wait_grants("t3_resume", 187, 100, c);
    vld_user[1] = 1'b0;
    step();
    vld_user[1] = 1'b1; credit_vld = 1'b1; credit_port = 4'd1; credit_amt = 8'd1;
    step();
    vld_user[1] = 1'b0; credit_vld = 1'b0;
    chk("t3_same_grant", gq.size(), 188);
    base = gq.size();
    vld_user[1] = 1'b1;
    repeat (20) step();
    vld_user[1] = 1'b0;
    chk("t3_after_same", gq.size() - base, 5);
    credit(1, 125);
    chk("t3_err_pre", credit_err, 0);
    credit(1, 10);
    chk("t3_err_sat", credit_err, 1);
    base = gq.size();
    vld_user[1] = 1'b1;
    repeat (140) step();
    vld_user[1] = 1'b0;
    chk("t3_sat_count", gq.size() - base, 128);

    // Stall mid-stream on port 2
    step(); step();
    gq.delete();
    vld_user[2] = 1'b1;
    wait_grants("t4_pre", 3, 10, c);
    stall = 1'b1;
    hold = dout_pkt;
    chk("t4_hold_vld", hold[48], 1);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t4_stall_ack", ack_user, 0);
      chk("t4_stall_dout", dout_pkt, hold);
      step();
    end
    stall = 1'b0;
    wait_grants("t4_post", 6, 20, c);
    vld_user[2] = 1'b0;

    // Backpressure: out_ready low holds the register and blocks grants
    step(); step();
    gq.delete();
    out_ready = 1'b0;
    vld_user[2] = 1'b1;
    repeat (4) step();
    chk("t4_bp", gq.size(), 1);
    out_ready = 1'b1;
    wait_grants("t4_bp_resume", 3, 10, c);
    vld_user[2] = 1'b0;

    // Address wrap on port 3, then reset mid-burst
    step(); step();
    cfg(3, 1'b1, 5'd7, 4'd11);
    gq.delete();
    vld_user[3] = 1'b1;
    wait_grants("t5_a", 100, 110, c);
    credit(3, 100);
    wait_grants("t5_b", 128, 40, c);
    chk("t5_addr127", dout_pkt[38:32], 127);
    step();
    chk("t5_addr0", dout_pkt[38:32], 0);
    wait_grants("t5_c", 130, 10, c);
    do_reset();
    cfg(3, 1'b1, 5'd7, 4'd11);
    wait_grants("t6_first", 1, 10, c);
    chk("t6_vld", dout_pkt[48], 1);
    chk("t6_addr0", dout_pkt[38:32], 0);
    vld_user[3] = 1'b0;

    // Out-of-range indices set the sticky error
    step(); step();
    chk("t7_pre", credit_err, 0);
    cfg(9, 1'b1, 5'd1, 4'd1);
    chk("t7_cfg_bad", credit_err, 1);
    do_reset();
    credit(12, 5);
    chk("t7_credit_bad", credit_err, 1);

    step(); step();
    chk("end_idle", dout_pkt[48], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
